ceespu_writeback: RTL and testbench

CEESPU_WRITEBACK -- requirements
Module: ceespu_writeback

---
 rtl/ceespu_pkg.sv | 29 ++
 rtl/ceespu_load_align.sv | 31 +++
 rtl/ceespu_writeback.sv | 105 ++++++++++
 tb/tb_ceespu_writeback.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ceespu_pkg.sv
// Shared definitions for the ceespu pipeline: writeback FSM states, load-size codes
// and the load misalignment rule.
package ceespu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_WRITE    = 2'b10
  } wbState_t;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } loadSize_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (loadSize_t'(size))
      LS_BYTE: bad = 1'b0;
      LS_HALF: bad = addrLo[0];
      LS_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ceespu_load_align.sv
// Little-endian lane select and sign/zero extension of a loaded data word.
module ceespu_load_align
  import ceespu_pkg::*;
(
  input  logic [31:0] I_rdata,
  input  logic [1:0]  I_size,
  input  logic        I_signed,
  input  logic [1:0]  I_addr_lo,
  output logic [31:0] O_data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    case (I_addr_lo)
      2'd0:    byteLane = I_rdata[7:0];
      2'd1:    byteLane = I_rdata[15:8];
      2'd2:    byteLane = I_rdata[23:16];
      default: byteLane = I_rdata[31:24];
    endcase
    halfLane = I_addr_lo[1] ? I_rdata[31:16] : I_rdata[15:0];

    case (loadSize_t'(I_size))
      LS_BYTE: O_data = {{24{I_signed & byteLane[7]}}, byteLane};
      LS_HALF: O_data = {{16{I_signed & halfLane[15]}}, halfLane};
      default: O_data = I_rdata;
    endcase
  end

endmodule

// File: rtl/ceespu_writeback.sv
// Writeback stage: registers ALU results or waits for load data, aligns it and
// drives the register-file write port; misaligned loads raise a one-cycle fault.
module ceespu_writeback
  import ceespu_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic        I_flush,
  input  logic        I_wb_en,
  input  logic [4:0]  I_selD,
  input  logic        I_is_load,
  input  logic [1:0]  I_load_size,
  input  logic        I_load_signed,
  input  logic [1:0]  I_addr_lo,
  input  logic [31:0] I_alu_result,
  input  logic        I_mem_rvalid,
  input  logic [31:0] I_mem_rdata,
  output logic        O_we,
  output logic [4:0]  O_selD,
  output logic [31:0] O_dataD,
  output logic        O_load_pending,
  output logic        O_misalign
);

  wbState_t    state;
  logic        pendWbEn;
  logic [4:0]  pendSel;
  logic [1:0]  pendSize;
  logic        pendSigned;
  logic [1:0]  pendAddr;
  logic [31:0] alignedData;
  logic        accept;

  assign O_ready        = (state != ST_WAIT_MEM);
  assign O_load_pending = (state == ST_WAIT_MEM);
  assign accept         = I_valid & O_ready & ~I_flush;

  ceespu_load_align u_align (
    .I_rdata   (I_mem_rdata),
    .I_size    (pendSize),
    .I_signed  (pendSigned),
    .I_addr_lo (pendAddr),
    .O_data    (alignedData)
  );

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state      <= ST_IDLE;
      O_we       <= 1'b0;
      O_selD     <= '0;
      O_dataD    <= '0;
      O_misalign <= 1'b0;
      pendWbEn   <= 1'b0;
      pendSel    <= '0;
      pendSize   <= '0;
      pendSigned <= 1'b0;
      pendAddr   <= '0;
    end else begin
      O_we       <= 1'b0;
      O_misalign <= 1'b0;
      case (state)
        ST_WAIT_MEM: begin
          // flush outranks a same-edge rvalid
          if (I_flush) begin
            state <= ST_IDLE;
          end else if (I_mem_rvalid) begin
            state <= ST_WRITE;
            if (pendWbEn && pendSel != '0) begin
              O_we    <= 1'b1;
              O_selD  <= pendSel;
              O_dataD <= alignedData;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          if (accept) begin
            if (I_is_load) begin
              if (isMisaligned(I_load_size, I_addr_lo)) begin
                O_misalign <= 1'b1;
              end else begin
                state      <= ST_WAIT_MEM;
                pendWbEn   <= I_wb_en;
                pendSel    <= I_selD;
                pendSize   <= I_load_size;
                pendSigned <= I_load_signed;
                pendAddr   <= I_addr_lo;
              end
            end else begin
              state <= ST_WRITE;
              if (I_wb_en && I_selD != '0) begin
                O_we    <= 1'b1;
                O_selD  <= I_selD;
                O_dataD <= I_alu_result;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_writeback.sv
// Directed and random checks of ceespu_writeback against a transaction-level model.
module tb_ceespu_writeback;

  logic        I_clk = 1'b0;
  logic        I_rst, I_valid, I_flush, I_wb_en, I_is_load, I_load_signed, I_mem_rvalid;
  logic [4:0]  I_selD;
  logic [1:0]  I_load_size, I_addr_lo;
  logic [31:0] I_alu_result, I_mem_rdata;
  logic        O_ready, O_we, O_load_pending, O_misalign;
  logic [4:0]  O_selD;
  logic [31:0] O_dataD;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // model: an outstanding load (if any) plus the expected register-file port
  logic        mBusy;
  logic        mWb;
  logic [4:0]  mSel;
  logic [1:0]  mSize, mAddr;
  logic        mSgn;
  logic        eWe, eMis;
  logic [4:0]  eSel;
  logic [31:0] eData;

  ceespu_writeback dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .O_ready(O_ready),
    .I_flush(I_flush), .I_wb_en(I_wb_en), .I_selD(I_selD), .I_is_load(I_is_load),
    .I_load_size(I_load_size), .I_load_signed(I_load_signed), .I_addr_lo(I_addr_lo),
    .I_alu_result(I_alu_result), .I_mem_rvalid(I_mem_rvalid), .I_mem_rdata(I_mem_rdata),
    .O_we(O_we), .O_selD(O_selD), .O_dataD(O_dataD),
    .O_load_pending(O_load_pending), .O_misalign(O_misalign)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] refAlign(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] addr);
    int unsigned width, shift, v;
    if (size == 2'd2) return rdata;
    width = (size == 2'd0) ? 8 : 16;
    shift = (size == 2'd0) ? 8 * addr : ((addr >= 2) ? 16 : 0);
    v = (rdata >> shift) % (32'd1 << width);
    if (sgn && v >= (32'd1 << (width - 1))) v = v - (32'd1 << width);
    return v;
  endfunction

  function automatic logic refMisaligned(input logic [1:0] size, input logic [1:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr != 0);
  endfunction

  task automatic clearIn();
    I_rst = 1'b1; I_valid = 1'b0; I_flush = 1'b0; I_wb_en = 1'b0; I_selD = '0;
    I_is_load = 1'b0; I_load_size = '0; I_load_signed = 1'b0; I_addr_lo = '0;
    I_alu_result = '0; I_mem_rvalid = 1'b0; I_mem_rdata = '0;
  endtask

  task automatic offer(input logic ld, input logic [4:0] sel, input logic [1:0] size,
                       input logic sgn, input logic [1:0] addr, input logic [31:0] alu);
    I_valid = 1'b1; I_wb_en = 1'b1; I_is_load = ld; I_selD = sel;
    I_load_size = size; I_load_signed = sgn; I_addr_lo = addr; I_alu_result = alu;
  endtask

  // one clock: advance the model on the edge, then compare every output
  task automatic step();
    @(posedge I_clk);
    if (!I_rst) begin
      mBusy = 1'b0; eWe = 1'b0; eMis = 1'b0; eSel = '0; eData = '0;
    end else begin
      eWe = 1'b0; eMis = 1'b0;
      if (mBusy) begin
        if (I_flush) mBusy = 1'b0;
        else if (I_mem_rvalid) begin
          mBusy = 1'b0;
          if (mWb && mSel != 0) begin
            eWe = 1'b1; eSel = mSel; eData = refAlign(I_mem_rdata, mSize, mSgn, mAddr);
          end
        end
      end else if (I_valid && !I_flush) begin
        if (I_is_load) begin
          if (refMisaligned(I_load_size, I_addr_lo)) eMis = 1'b1;
          else begin
            mBusy = 1'b1; mWb = I_wb_en; mSel = I_selD;
            mSize = I_load_size; mSgn = I_load_signed; mAddr = I_addr_lo;
          end
        end else if (I_wb_en && I_selD != 0) begin
          eWe = 1'b1; eSel = I_selD; eData = I_alu_result;
        end
      end
    end
    #1;
    chk("we", O_we, eWe);
    chk("selD", O_selD, eSel);
    chk("dataD", O_dataD, eData);
    chk("misalign", O_misalign, eMis);
    chk("ready", O_ready, !mBusy);
    chk("pending", O_load_pending, mBusy);
  endtask

  initial begin
    mBusy = 1'b0; mWb = 1'b0; mSel = '0; mSize = '0; mAddr = '0; mSgn = 1'b0;
    eWe = 1'b0; eMis = 1'b0; eSel = '0; eData = '0;
    clearIn();
    I_rst = 1'b0;
    step();
    chk("rst_we", O_we, 0); chk("rst_data", O_dataD, 0); chk("rst_ready", O_ready, 1);
    clearIn();
    step();

    // ALU result lands one cycle after acceptance
    offer(1'b0, 5'd5, 2'd0, 1'b0, 2'd0, 32'h12345678);
    step();
    chk("alu_we", O_we, 1); chk("alu_sel", O_selD, 5); chk("alu_data", O_dataD, 32'h12345678);
    clearIn();

    // signed byte, lane 3
    offer(1'b1, 5'd7, 2'd0, 1'b1, 2'd3, 32'h0);
    step(); chk("sb_ready0", O_ready, 0);
    clearIn();
    step(); chk("sb_ready1", O_ready, 0);
    I_mem_rvalid = 1'b1; I_mem_rdata = 32'h80FF0011;
    step();
    chk("sb_we", O_we, 1); chk("sb_sel", O_selD, 7); chk("sb_data", O_dataD, 32'hFFFFFF80);
    clearIn();

    // unsigned half, upper lane
    offer(1'b1, 5'd9, 2'd1, 1'b0, 2'd2, 32'h0);
    step(); clearIn();
    I_mem_rvalid = 1'b1; I_mem_rdata = 32'hBEEF1234;
    step();
    chk("uh_data", O_dataD, 32'h0000BEEF); chk("uh_we", O_we, 1);
    clearIn();

    // same half load at an odd address faults
    offer(1'b1, 5'd9, 2'd1, 1'b0, 2'd1, 32'h0);
    step();
    chk("mis_pulse", O_misalign, 1); chk("mis_we", O_we, 0); chk("mis_ready", O_ready, 1);
    clearIn();
    step(); chk("mis_clear", O_misalign, 0);

    // r0 is never written and outputs hold
    offer(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 32'hFFFFFFFF);
    step();
    chk("r0_we", O_we, 0); chk("r0_hold", O_dataD, 32'h0000BEEF);
    clearIn();

    // flush beats rvalid on the same edge
    offer(1'b1, 5'd3, 2'd2, 1'b0, 2'd0, 32'h0);
    step(); clearIn();
    I_flush = 1'b1; I_mem_rvalid = 1'b1; I_mem_rdata = 32'hCAFEF00D;
    step();
    chk("fl_we", O_we, 0); chk("fl_ready", O_ready, 1); chk("fl_pend", O_load_pending, 0);
    clearIn();

    // reset mid-load discards it
    offer(1'b1, 5'd4, 2'd2, 1'b0, 2'd0, 32'h0);
    step(); clearIn();
    I_rst = 1'b0;
    step();
    chk("rl_data", O_dataD, 0); chk("rl_sel", O_selD, 0); chk("rl_pend", O_load_pending, 0);
    clearIn();
    I_mem_rvalid = 1'b1; I_mem_rdata = 32'h11223344;
    step();
    chk("rl_we", O_we, 0); chk("rl_data2", O_dataD, 0);
    clearIn();

    for (int i = 0; i < 3000; i++) begin
      I_rst         = ($urandom_range(0, 99) != 0);
      I_valid       = ($urandom_range(0, 99) < 60);
      I_flush       = ($urandom_range(0, 99) < 8);
      I_wb_en       = ($urandom_range(0, 99) < 85);
      I_selD        = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      I_is_load     = ($urandom_range(0, 99) < 45);
      I_load_size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      I_load_signed = 1'($urandom);
      I_addr_lo     = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
      I_alu_result  = $urandom;
      I_mem_rvalid  = ($urandom_range(0, 99) < 35);
      I_mem_rdata   = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
